uart_pwm_cmd: RTL
=================

# uart_pwm_cmd

Command parser and configuration controller between the UART receiver and the PWM generators. It consumes received bytes, one per valid pulse, and assembles them into fixed 5-byte command frames. It validates each frame and writes a 16-bit duty value into one of `CH_NUM` per-channel duty registers. It also enforces an inter-byte timeout so that a broken frame can never stall the link.

## Interface

**Parameters**
- `CH_NUM`, default 4: number of PWM channels, range 1..16.
- `PERIOD`, default 16'd1000: PWM period in clocks. Duty values above this are clamped to it.
- `TIMEOUT`, default 17360: maximum clocks between bytes of one frame. Two byte times at 868 clk/bit.

**Ports** (reset rst, synchronous, active-high; clock clk)
- `clk`, in, 1: system clock.
- `rst`, in, 1: synchronous, active-high reset.
- `rx_data`, in, 8: received byte. Valid only while `rx_valid` is high.
- `rx_valid`, in, 1: single-cycle byte-valid pulse from the receiver.
- `duty`, out, 16*CH_NUM: registered duty values. Channel k occupies bits [16k+15:16k].
- `duty_upd`, out, CH_NUM: one-cycle pulse, one bit per channel, asserted when that channel is written.
- `frame_err`, out, 1: one-cycle pulse on a rejected frame.
- `busy`, out, 1: high while a frame is being received (state other than IDLE).

## Operation

- **Frame format:** 0xAA header, CH, DH, DL, CK.
  - Duty value D = {DH, DL}.
  - CK = CH ^ DH ^ DL.
- **FSM states:** IDLE → CH → DH → DL → CK → IDLE.
  - The FSM advances only on cycles where `rx_valid` = 1.
- **IDLE:** 0xAA moves to CH. Any other byte is discarded silently, with no error.
- **CH, DH, DL:** the byte is latched and the running XOR is updated.
  - The XOR is cleared on entry to CH.
  - The CH byte is stored in full 8 bits, so range checking happens later.
- **CK state, on the checksum byte:** return to IDLE and apply these checks in priority order.
  1. Checksum mismatch → `frame_err` pulse, no register write.
  2. CH ≥ CH_NUM → `frame_err` pulse, no register write.
  3. Otherwise:
     - `duty[CH]` is set to min(D, PERIOD). The comparison is unsigned 16-bit.
     - `duty_upd[CH]` pulses.
- **Header inside a frame:** a 0xAA byte received in CH, DH or DL is treated as data, not as a resync.
- **Inter-byte timer:**
  - Cleared on every `rx_valid`.
  - Counts up while the state is not IDLE.
  - Held at 0 while in IDLE.
  - Width is clog2(TIMEOUT+1).
- **Timeout:**
  - When the timer reaches TIMEOUT-1 with no `rx_valid` in that cycle, the FSM goes to IDLE and `frame_err` pulses.
  - If `rx_valid` arrives in that same cycle, the byte wins: the frame proceeds normally and no timeout occurs.
- **Untouched channels** keep their values indefinitely.
- **Reset:**
  - Takes effect mid-frame with no error pulse.
  - FSM to IDLE, timer 0, XOR 0.
  - All `duty` = 0, `duty_upd` = 0, `frame_err` = 0, `busy` = 0.

## Timing

- All outputs are registered.
- **Latency:** the `rx_valid` edge of the CK byte is followed one clock later by the new `duty[CH]` value and the `duty_upd[CH]` pulse, both visible in the same cycle.
- `frame_err` also appears one clock after the offending `rx_valid`, or one clock after the timeout cycle.
- `duty_upd` and `frame_err` are mutually exclusive in any cycle.
- Each is high for exactly one clock per event.
- `busy` rises one clock after the header byte and falls one clock after the CK byte or the timeout.
- **Back-to-back frames:** a header arriving on the cycle immediately after the CK byte is accepted. There are no dead cycles.
- `rx_valid` asserted for multiple consecutive cycles counts as one byte per cycle. The upstream guarantees single-cycle pulses.

## Test plan

- **Valid frame:** AA 01 01 23 23 (CH_NUM = 4). Expect `duty[1]` = 0x0123, `duty_upd` = 4'b0010 for one clock, `frame_err` = 0, all other channels unchanged at 0.
- **Clamp:** AA 02 FF FF 02. Expect `duty[2]` = 1000 (PERIOD), `duty_upd` = 4'b0100.
- **Bad checksum, then bad channel:**
  - AA 00 00 10 11: `frame_err` pulse, `duty[0]` unchanged.
  - AA 05 00 10 15: `frame_err` pulse, no `duty_upd`.
- **Garbage and back-to-back:**
  - 55 33 AA 03 00 64 67, then AA 00 00 05 05 immediately after.
  - Garbage ignored with no error.
  - `duty[3]` = 100, then `duty[0]` = 5, with two separate `duty_upd` pulses.
- **Timeout:**
  - AA 01, then idle for TIMEOUT cycles: `frame_err` pulse, `busy` low.
  - Then AA 01 00 07 06: `duty[1]` = 7.
  - Repeat with the byte landing exactly on the TIMEOUT-1 cycle: no error.
- **Reset mid-frame:**
  - After AA 01 00, assert `rst` for one clock.
  - All duty = 0, `busy` = 0, no pulses.
  - A subsequent full valid frame is accepted.

Source files
------------

// File: rtl/uart_pwm_cmd_if.sv
// ---------------------------------------------------------------------------
// uart_pwm_cmd_if
// Link between the UART receiver side and the PWM command parser.
//   rx_data   : received byte, qualified by rx_valid
//   rx_valid  : single-cycle byte-valid pulse
//   duty      : packed per-channel duty registers, channel k at [16k+15:16k]
//   duty_upd  : one-cycle write pulse per channel
//   frame_err : one-cycle pulse on a rejected or timed-out frame
//   busy      : parser is inside a frame
// master drives the received bytes; slave is the parser.
// ---------------------------------------------------------------------------
interface uart_pwm_cmd_if #(
    parameter int CH_NUM = 4
);
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic [16*CH_NUM-1:0]  duty;
    logic [CH_NUM-1:0]     duty_upd;
    logic                  frame_err;
    logic                  busy;

    modport master (
        output rx_data, rx_valid,
        input  duty, duty_upd, frame_err, busy
    );

    modport slave (
        input  rx_data, rx_valid,
        output duty, duty_upd, frame_err, busy
    );
endinterface

// File: rtl/uart_pwm_cmd.sv
// ---------------------------------------------------------------------------
// uart_pwm_cmd
// Assembles 5-byte frames (AA, CH, DH, DL, CK with CK = CH^DH^DL) from the
// UART byte stream and writes min({DH,DL}, PERIOD) into duty register CH.
// A frame whose bytes are more than TIMEOUT clocks apart is abandoned.
//   clk : system clock
//   rst : synchronous, active-high reset
//   bus : uart_pwm_cmd_if.slave (rx_data/rx_valid in; duty, duty_upd,
//         frame_err, busy out -- all outputs registered)
// ---------------------------------------------------------------------------
module uart_pwm_cmd #(
    parameter int          CH_NUM  = 4,
    parameter logic [15:0] PERIOD  = 16'd1000,
    parameter int          TIMEOUT = 17360
) (
    input  logic           clk,
    input  logic           rst,
    uart_pwm_cmd_if.slave  bus
);

    localparam int            TW         = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [7:0]    CH_LIMIT   = 8'(CH_NUM);
    localparam logic [7:0]    HEADER     = 8'hAA;

    typedef enum logic [2:0] {S_IDLE, S_CH, S_DH, S_DL, S_CK} state_t;

    state_t               state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [7:0]           ch_q, ch_d;
    logic [7:0]           dh_q, dh_d;
    logic [7:0]           dl_q, dl_d;
    logic [7:0]           xor_q, xor_d;
    logic [16*CH_NUM-1:0] duty_q, duty_d;
    logic [CH_NUM-1:0]    duty_upd_q, duty_upd_d;
    logic                 frame_err_q, frame_err_d;
    logic                 busy_q, busy_d;

    logic [15:0]          duty_val;
    logic [15:0]          duty_clamped;
    logic                 timeout;

    // A byte arriving on the last timer cycle wins over the timeout.
    always_comb begin
        duty_val     = {dh_q, dl_q};
        duty_clamped = (duty_val > PERIOD) ? PERIOD : duty_val;
        timeout      = (state_q != S_IDLE) && !bus.rx_valid && (timer_q == TIMER_LAST);
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        state_d     = state_q;
        ch_d        = ch_q;
        dh_d        = dh_q;
        dl_d        = dl_q;
        xor_d       = xor_q;
        duty_d      = duty_q;
        duty_upd_d  = '0;
        frame_err_d = 1'b0;

        if (timeout) begin
            state_d     = S_IDLE;
            frame_err_d = 1'b1;
        end else if (bus.rx_valid) begin
            unique case (state_q)
                S_IDLE: begin
                    // Non-header bytes are dropped silently while idle.
                    if (bus.rx_data == HEADER) begin
                        state_d = S_CH;
                        xor_d   = '0;
                    end
                end
                S_CH: begin
                    ch_d    = bus.rx_data;
                    xor_d   = xor_q ^ bus.rx_data;
                    state_d = S_DH;
                end
                S_DH: begin
                    dh_d    = bus.rx_data;
                    xor_d   = xor_q ^ bus.rx_data;
                    state_d = S_DL;
                end
                S_DL: begin
                    dl_d    = bus.rx_data;
                    xor_d   = xor_q ^ bus.rx_data;
                    state_d = S_CK;
                end
                S_CK: begin
                    state_d = S_IDLE;
                    if (bus.rx_data != xor_q) begin
                        frame_err_d = 1'b1;
                    end else if (ch_q >= CH_LIMIT) begin
                        frame_err_d = 1'b1;
                    end else begin
                        // Decode by comparison so an out-of-range CH never
                        // forms an out-of-range part-select.
                        for (int k = 0; k < CH_NUM; k++) begin
                            if (ch_q == 8'(k)) begin
                                duty_d[16*k +: 16] = duty_clamped;
                                duty_upd_d[k]      = 1'b1;
                            end
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Timer restarts on each byte and rests at zero whenever idle.
        timer_d = (bus.rx_valid || state_d == S_IDLE) ? '0 : timer_q + 1'b1;
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            ch_q        <= '0;
            dh_q        <= '0;
            dl_q        <= '0;
            xor_q       <= '0;
            // NOTE: the duty registers are architectural state seen by the
            // PWM generators, so they are reset too, not left to power-up.
            duty_q      <= '0;
            duty_upd_q  <= '0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge value of the others.
            state_q     <= state_d;
            timer_q     <= timer_d;
            ch_q        <= ch_d;
            dh_q        <= dh_d;
            dl_q        <= dl_d;
            xor_q       <= xor_d;
            duty_q      <= duty_d;
            duty_upd_q  <= duty_upd_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.duty      = duty_q;
    assign bus.duty_upd  = duty_upd_q;
    assign bus.frame_err = frame_err_q;
    assign bus.busy      = busy_q;

endmodule
